// File: rtl/axi_burst_master_if.sv
// AXI-style write/read channel bundle between the burst master and the DDR2 slave port.
// Carries the address, data and response channels with master/slave modports.
interface axi_burst_master_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 16
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  wvalid;
  logic                  wready;
  logic                  wlast;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  bvalid;
  logic                  bready;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  rvalid;
  logic                  rready;
  logic                  rlast;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output awvalid, awaddr, awlen,
    input  awready,
    output wvalid, wlast, wdata,
    input  wready,
    input  bvalid,
    output bready,
    output arvalid, araddr, arlen,
    input  arready,
    input  rvalid, rlast, rdata,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen,
    output awready,
    input  wvalid, wlast, wdata,
    output wready,
    output bvalid,
    input  bready,
    input  arvalid, araddr, arlen,
    output arready,
    output rvalid, rlast, rdata,
    input  rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// Traffic generator: each trigger edge after DDR2 init runs one write burst,
// then a read burst of the same length from the same base address.
module axi_burst_master #(
  parameter int         ADDR_WIDTH = 27,
  parameter int         DATA_WIDTH = 16,
  parameter int         DATA_LEVEL = 2,
  parameter logic [7:0] WBURST_LEN = 8'd8,
  parameter logic [7:0] RBURST_LEN = 8'd8
) (
  input  logic clk,
  input  logic rst,
  input  logic w_trig,
  input  logic init_end,
  axi_burst_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, AW, W, B, AR, R
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] STRIDE =
    ADDR_WIDTH'(int'(WBURST_LEN) * DATA_LEVEL);

  state_t                state, state_n;
  logic                  trig_d;
  logic [ADDR_WIDTH-1:0] base, base_n;
  logic [DATA_WIDTH-1:0] cnt, cnt_n;
  logic [7:0]            beat, beat_n;

  logic                  awvalid_n, wvalid_n, wlast_n;
  logic                  bready_n, arvalid_n, rready_n;
  logic [ADDR_WIDTH-1:0] awaddr_n, araddr_n;
  logic [7:0]            awlen_n, arlen_n;
  logic [DATA_WIDTH-1:0] wdata_n;

  logic start;
  assign start = w_trig & ~trig_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      trig_d      <= 1'b0;
      base        <= '0;
      cnt         <= '0;
      beat        <= '0;
      bus.awvalid <= 1'b0;
      bus.awaddr  <= '0;
      bus.awlen   <= '0;
      bus.wvalid  <= 1'b0;
      bus.wlast   <= 1'b0;
      bus.wdata   <= '0;
      bus.bready  <= 1'b0;
      bus.arvalid <= 1'b0;
      bus.araddr  <= '0;
      bus.arlen   <= '0;
      bus.rready  <= 1'b0;
    end else begin
      state       <= state_n;
      trig_d      <= w_trig;
      base        <= base_n;
      cnt         <= cnt_n;
      beat        <= beat_n;
      bus.awvalid <= awvalid_n;
      bus.awaddr  <= awaddr_n;
      bus.awlen   <= awlen_n;
      bus.wvalid  <= wvalid_n;
      bus.wlast   <= wlast_n;
      bus.wdata   <= wdata_n;
      bus.bready  <= bready_n;
      bus.arvalid <= arvalid_n;
      bus.araddr  <= araddr_n;
      bus.arlen   <= arlen_n;
      bus.rready  <= rready_n;
    end
  end

  always_comb begin
    state_n   = state;
    base_n    = base;
    cnt_n     = cnt;
    beat_n    = beat;
    awvalid_n = bus.awvalid;
    awaddr_n  = bus.awaddr;
    awlen_n   = bus.awlen;
    wvalid_n  = bus.wvalid;
    wlast_n   = bus.wlast;
    wdata_n   = bus.wdata;
    bready_n  = bus.bready;
    arvalid_n = bus.arvalid;
    araddr_n  = bus.araddr;
    arlen_n   = bus.arlen;
    rready_n  = bus.rready;
    unique case (state)
      IDLE: if (start && init_end) begin
        awvalid_n = 1'b1;
        awaddr_n  = base;
        awlen_n   = WBURST_LEN - 8'd1;
        beat_n    = '0;
        state_n   = AW;
      end
      AW: if (bus.awready) begin
        awvalid_n = 1'b0;
        wvalid_n  = 1'b1;
        wdata_n   = cnt;
        wlast_n   = (WBURST_LEN == 8'd1);
        state_n   = W;
      end
      W: if (bus.wready) begin
        cnt_n   = cnt + 1'b1;
        wdata_n = cnt_n;
        beat_n  = beat + 8'd1;
        wlast_n = (beat_n == WBURST_LEN - 8'd1);
        if (bus.wlast) begin
          wvalid_n = 1'b0;
          wlast_n  = 1'b0;
          bready_n = 1'b1;
          state_n  = B;
        end
      end
      B: if (bus.bvalid) begin
        bready_n  = 1'b0;
        arvalid_n = 1'b1;
        araddr_n  = base;
        arlen_n   = RBURST_LEN - 8'd1;
        state_n   = AR;
      end
      AR: if (bus.arready) begin
        arvalid_n = 1'b0;
        rready_n  = 1'b1;
        state_n   = R;
      end
      R: if (bus.rvalid && bus.rlast) begin
        rready_n = 1'b0;
        base_n   = base + STRIDE;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master with a responsive slave model
// and a handshake monitor; checks use immediate assertions.
module tb_axi_burst_master;

  logic clk = 1'b0;
  logic rst, w_trig, init_end;
  logic wgap;

  axi_burst_master_if #(.ADDR_WIDTH(27), .DATA_WIDTH(16)) bus ();

  axi_burst_master dut (
    .clk      (clk),
    .rst      (rst),
    .w_trig   (w_trig),
    .init_end (init_end),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  int cyc = 0;
  int aw_cnt = 0;
  int done_cnt = 0;
  int rcnt = 0;
  int b_cyc = 0;
  int ar_cyc = 0;
  logic [26:0] aw_addr, ar_addr;
  logic [7:0]  aw_len, ar_len;
  logic [15:0] wq[$];
  logic        lq[$];

  always @(negedge clk) begin
    bus.wready = wgap ? 1'($urandom_range(0, 1)) : 1'b1;
    bus.bvalid = bus.bready;
    bus.rvalid = bus.rready;
    bus.rlast  = bus.rready && (rcnt == 7);
    bus.rdata  = 16'(rcnt);
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (bus.awvalid && bus.awready) begin
        aw_cnt  <= aw_cnt + 1;
        aw_addr <= bus.awaddr;
        aw_len  <= bus.awlen;
      end
      if (bus.wvalid && bus.wready) begin
        wq.push_back(bus.wdata);
        lq.push_back(bus.wlast);
      end
      if (bus.bvalid && bus.bready) b_cyc <= cyc;
      if (bus.arvalid && bus.arready) begin
        ar_cyc  <= cyc;
        ar_addr <= bus.araddr;
        ar_len  <= bus.arlen;
      end
      if (bus.rvalid && bus.rready) begin
        if (bus.rlast) begin
          rcnt     <= 0;
          done_cnt <= done_cnt + 1;
        end else begin
          rcnt <= rcnt + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse();
    w_trig = 1'b1;
    @(negedge clk);
    w_trig = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 500 && done_cnt < target; i++) @(negedge clk);
    check("done_wait", done_cnt, target);
  endtask

  task automatic check_burst(input string tag, input logic [15:0] first);
    logic [7:0] lp;
    check({tag, "_nbeats"}, wq.size(), 8);
    lp = '0;
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      check({tag, "_wdata"}, wq[i], first + 16'(i));
      lp[i] = lq[i];
    end
    check({tag, "_wlast"}, lp, 8'h80);
  endtask

  initial begin
    int n0;
    bit stable;
    logic [26:0] a0;
    rst = 1'b1; w_trig = 1'b0; init_end = 1'b0; wgap = 1'b0;
    bus.awready = 1'b1; bus.arready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_awvalid", bus.awvalid, 0);
    check("rst_wvalid", bus.wvalid, 0);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_outs", {bus.bready, bus.rready, bus.wlast}, 0);
    check("rst_awaddr", bus.awaddr, 0);

    pulse();
    repeat (5) @(negedge clk);
    check("noinit_aw", aw_cnt, 0);
    init_end = 1'b1;
    repeat (3) @(negedge clk);
    check("noinit_awvalid", bus.awvalid, 0);

    wq.delete(); lq.delete();
    pulse();
    wait_done(1);
    check("t2_awaddr", aw_addr, 0);
    check("t2_awlen", aw_len, 7);
    check_burst("t2", 16'd0);
    check("t2_araddr", ar_addr, 0);
    check("t2_arlen", ar_len, 7);
    check("t2_ar_after_b", ar_cyc > b_cyc, 1);

    wq.delete(); lq.delete();
    pulse();
    wait_done(2);
    check("t3_awaddr", aw_addr, 16);
    check("t3_araddr", ar_addr, 16);
    check_burst("t3", 16'd8);

    wq.delete(); lq.delete();
    bus.awready = 1'b0;
    pulse();
    for (int i = 0; i < 20 && !bus.awvalid; i++) @(negedge clk);
    a0 = bus.awaddr;
    stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!bus.awvalid || bus.awaddr !== a0) stable = 1'b0;
    end
    check("t4_aw_stable", stable, 1);
    check("t4_awaddr", a0, 32);
    bus.awready = 1'b1;
    wgap = 1'b1;
    wait_done(3);
    wgap = 1'b0;
    check_burst("t4", 16'd16);

    n0 = aw_cnt;
    w_trig = 1'b1;
    wait_done(4);
    repeat (20) @(negedge clk);
    check("t5_held_once", aw_cnt - n0, 1);
    check("t5_held_idle", bus.awvalid, 0);
    w_trig = 1'b0;
    @(negedge clk);

    n0 = aw_cnt;
    pulse();
    for (int i = 0; i < 100 && !bus.rready; i++) @(negedge clk);
    check("t5_in_r", bus.rready, 1);
    pulse();
    wait_done(5);
    repeat (10) @(negedge clk);
    check("t5_r_ignored", aw_cnt - n0, 1);
    check("t5_araddr", ar_addr, 64);

    wq.delete(); lq.delete();
    pulse();
    for (int i = 0; i < 100 && wq.size() < 3; i++) @(negedge clk);
    check("t6_in_w", bus.wvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_valids",
          {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    check("t6_rst_wdata", {bus.wlast, bus.wdata}, 0);
    check("t6_rst_addr", {bus.awaddr, bus.araddr}, 0);
    check("t6_rst_len", {bus.awlen, bus.arlen}, 0);
    rst = 1'b0;
    @(negedge clk);
    wq.delete(); lq.delete();
    pulse();
    wait_done(6);
    check("t6_awaddr", aw_addr, 0);
    check_burst("t6", 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
